cis_line_sequencer: RTL and testbench
=====================================

// Module: cis_line_sequencer
// PURPOSE
//  Sequences one contact-image-sensor line readout: issues the SI start pulse, counts
//  DUMMY_PIX dummy then ACTIVE_PIX active pixel clocks, and tags active pixels for the
//  downstream ADC/line-buffer path.
//  Line starts come from the encoder decoder (LINE_TRIG) or an internal free-run timer.
//  Also drives the LED colour (mono or R/G/B rotation) and flags trigger overruns.
// PARAMETERS
//  DUMMY_PIX   89     dummy pixel clocks after the SI cycle, before the first active pixel
//  ACTIVE_PIX  2592   active pixels per line
//  SI_WIDTH    1      SI high time in CLK cycles (>=1)
//  PERIOD_W    20     width of FREE_PERIOD and of the free-run timer
// PORTS
//  CLK          in   1         system clock; sensor pixel clock runs at this rate
//  RST          in   1         synchronous, active-high reset
//  EN           in   1         1 = accept line starts; 0 = finish current line, then idle
//  MODE         in   1         1 = encoder triggered (LINE_TRIG); 0 = free-run timer
//  FREE_PERIOD  in   PERIOD_W  free-run line period in CLK cycles; 0 = no free-run triggers
//  LINE_TRIG    in   1         1-cycle line request from encoder decoder (ignored when MODE=0)
//  RGB_MODE     in   1         1 = rotate R,G,B per line; 0 = mono (all LEDs on)
//  SI           out  1         sensor start pulse
//  LED_RGB      out  3         LED enables {B,G,R}
//  PIX_VALID    out  1         current cycle carries an active pixel
//  PIX_IDX      out  12        active pixel index, 0..ACTIVE_PIX-1
//  LINE_START   out  1         1-cycle pulse coincident with first SI cycle
//  LINE_END     out  1         1-cycle pulse coincident with last PIX_VALID
//  LINE_COLOR   out  2         colour of current line: 0=R, 1=G, 2=B, 3=mono
//  BUSY         out  1         FSM not in IDLE
//  OVERRUN      out  1         1-cycle pulse when a request is dropped
//  LINE_CNT     out  16        completed lines, wraps at 2^16
//  OVR_CNT      out  16        dropped requests, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset:
//   - all outputs 0; FSM=IDLE; pending flag, timer and colour index cleared (next colour R).
//   - RST mid-line aborts immediately; the aborted line is not counted.
//  Requests:
//   - MODE=1: LINE_TRIG is the request.
//   - MODE=0, FREE_PERIOD!=0: timer counts FREE_PERIOD-1..0 and requests on 0, then reloads.
//   - MODE=0, FREE_PERIOD=0: no requests.
//   - Timer starts from FREE_PERIOD-1 on the first cycle with EN=1 && MODE=0.
//   - Timer is held at reload while EN=0 or MODE=1.
//   - Requests are ignored while EN=0.
//  One-deep pending latch:
//   - Request in IDLE with no pending: line starts next cycle.
//   - Request while BUSY and none pending: sets pending.
//   - Request while pending already set: dropped; OVERRUN=1 for one cycle, OVR_CNT+1.
//   - Pending is served on the cycle after LINE_END (gap of exactly 1 IDLE cycle).
//   - EN=0 clears pending.
//  FSM: IDLE -> SI_PH (SI_WIDTH cycles) -> DUMMY (DUMMY_PIX cycles) -> ACTIVE (ACTIVE_PIX cycles) -> IDLE
//   - First SI cycle = T0; LINE_START=1 at T0.
//   - PIX_VALID=1 on T0+SI_WIDTH+DUMMY_PIX through T0+SI_WIDTH+DUMMY_PIX+ACTIVE_PIX-1.
//   - PIX_IDX increments 0..ACTIVE_PIX-1 there; PIX_IDX=0 when PIX_VALID=0.
//   - LINE_END with last pixel; LINE_CNT increments the cycle after LINE_END.
//   - Minimum line period = SI_WIDTH+DUMMY_PIX+ACTIVE_PIX+1 cycles.
//  LED / colour:
//   - LED_RGB and LINE_COLOR update at T0 only and are held until the next T0.
//   - RGB_MODE=1: LED_RGB = 001, 010, 100 rotating (R,G,B,R...); LINE_COLOR = 0,1,2.
//   - RGB_MODE=0: LED_RGB=111, LINE_COLOR=3; colour index does not advance.
//   - EN=0 and IDLE: LED_RGB=000.
//   - RGB_MODE change takes effect at the next T0; the rotation resumes where it stopped.
//  EN falling mid-line: current line completes normally (PIX_VALID, LINE_END, LINE_CNT).
//  Simultaneous request and LINE_END: the request is treated as arriving while BUSY.
// TESTING
//  1. MODE=1, single LINE_TRIG at cycle 10 -> SI=1 at cycle 11; PIX_VALID cycles 101..2692,
//     PIX_IDX 0..2591; LINE_END at 2692; LINE_CNT=1 at cycle 2693.
//  2. MODE=1, RGB_MODE=1, 4 triggers spaced 5000 cycles -> LED_RGB 001,010,100,001;
//     LINE_COLOR 0,1,2,0.
//  3. Triggers at +0, +100 and +200 (within one line) -> 2nd starts line cycle after LINE_END;
//     3rd gives OVERRUN pulse and OVR_CNT=1; LINE_CNT=2.
//  4. MODE=0, FREE_PERIOD=4000, EN=1 for 40000 cycles -> exactly 10 lines, no OVERRUN.
//     Then FREE_PERIOD=1000 -> continuous back-to-back lines, OVR_CNT rising.
//  5. RST at PIX_IDX=1000 -> next cycle all outputs 0, LINE_CNT unchanged at 0.
//     Next trigger -> colour R.
//  6. EN dropped at PIX_IDX=500 with request pending -> line finishes with LINE_END;
//     no further SI; LED_RGB=000.

Source files
------------

// File: rtl/cis_line_sequencer.sv
// cis_line_sequencer
//   Sequences one contact-image-sensor line readout. A line request produces an
//   SI start pulse, DUMMY_PIX dummy pixel clocks and ACTIVE_PIX active pixel
//   clocks. Active pixels are tagged with PIX_VALID/PIX_IDX for the downstream
//   ADC and line-buffer path.
//   Requests come either from the encoder decoder (LINE_TRIG, MODE=1) or from an
//   internal free-run timer (MODE=0). One request can wait in a pending latch
//   while a line is running; any further request is dropped and reported.
//   The LED colour is latched at each line start (mono, or R/G/B rotation).
//   Assumes DUMMY_PIX >= 1, ACTIVE_PIX >= 1, SI_WIDTH >= 1, ACTIVE_PIX <= 4096.
//
// Ports
//   CLK          in   system / pixel clock
//   RST          in   synchronous active-high reset
//   EN           in   accept line starts (0: finish current line, then idle)
//   MODE         in   1 = LINE_TRIG requests, 0 = free-run timer requests
//   FREE_PERIOD  in   free-run line period in CLK cycles (0 = no requests)
//   LINE_TRIG    in   one-cycle line request from the encoder decoder
//   RGB_MODE     in   1 = rotate R,G,B per line, 0 = mono
//   SI           out  sensor start pulse
//   LED_RGB      out  LED enables {B,G,R}
//   PIX_VALID    out  current cycle carries an active pixel
//   PIX_IDX      out  active pixel index (0 when PIX_VALID=0)
//   LINE_START   out  pulse on the first SI cycle
//   LINE_END     out  pulse on the last active pixel
//   LINE_COLOR   out  colour of current line: 0=R 1=G 2=B 3=mono
//   BUSY         out  a line is in progress
//   OVERRUN      out  pulse when a request is dropped
//   LINE_CNT     out  completed lines (wrapping)
//   OVR_CNT      out  dropped requests (saturating)

module cis_line_sequencer #(
  parameter int DUMMY_PIX  = 89,
  parameter int ACTIVE_PIX = 2592,
  parameter int SI_WIDTH   = 1,
  parameter int PERIOD_W   = 20
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                EN,
  input  logic                MODE,
  input  logic [PERIOD_W-1:0] FREE_PERIOD,
  input  logic                LINE_TRIG,
  input  logic                RGB_MODE,
  output logic                SI,
  output logic [2:0]          LED_RGB,
  output logic                PIX_VALID,
  output logic [11:0]         PIX_IDX,
  output logic                LINE_START,
  output logic                LINE_END,
  output logic [1:0]          LINE_COLOR,
  output logic                BUSY,
  output logic                OVERRUN,
  output logic [15:0]         LINE_CNT,
  output logic [15:0]         OVR_CNT
);

  localparam int CNT_MAX = (SI_WIDTH > DUMMY_PIX) ? SI_WIDTH : DUMMY_PIX;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SI_PH  = 2'd1,
    DUMMY  = 2'd2,
    ACTIVE = 2'd3
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic                pending;
  logic [1:0]          cidx;
  logic [2:0]          led_q;

  logic [PERIOD_W-1:0] tmr;
  logic                tmr_run;
  logic [PERIOD_W-1:0] tmr_cur;
  logic                tmr_en;
  logic                tmr_fire;
  logic                req;
  logic                drop;
  logic                start_now;

  // Free-run timer. While not running it presents FREE_PERIOD-1, so the first
  // enabled cycle always starts a full period regardless of what was stored.
  assign tmr_en   = EN & ~MODE;
  assign tmr_cur  = tmr_run ? tmr : (FREE_PERIOD - PERIOD_W'(1));
  assign tmr_fire = tmr_en && (FREE_PERIOD != '0) && (tmr_cur == '0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      tmr     <= '0;
      tmr_run <= 1'b0;
    end else if (!tmr_en) begin
      tmr     <= FREE_PERIOD - PERIOD_W'(1);
      tmr_run <= 1'b0;
    end else begin
      tmr_run <= 1'b1;
      tmr     <= (tmr_cur == '0) ? (FREE_PERIOD - PERIOD_W'(1)) : (tmr_cur - PERIOD_W'(1));
    end
  end

  // Request arbitration. A request arriving with the pending latch already full
  // is dropped, including in the single IDLE cycle where the pending request
  // itself is being launched.
  assign req       = EN && (MODE ? LINE_TRIG : tmr_fire);
  assign drop      = req && pending;
  assign start_now = (state == IDLE) && EN && (pending || req);

  always_ff @(posedge CLK) begin
    if (RST) begin
      pending <= 1'b0;
      OVERRUN <= 1'b0;
      OVR_CNT <= '0;
    end else begin
      OVERRUN <= drop;
      if (drop && (OVR_CNT != 16'hFFFF)) begin
        OVR_CNT <= OVR_CNT + 16'd1;
      end
      // In IDLE the pending request (or a fresh one) launches immediately, so
      // the latch only ever holds while a line is running.
      if (!EN || (state == IDLE)) begin
        pending <= 1'b0;
      end else if (req) begin
        pending <= 1'b1;
      end
    end
  end

  // Line FSM with registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      cnt        <= '0;
      SI         <= 1'b0;
      PIX_VALID  <= 1'b0;
      PIX_IDX    <= '0;
      LINE_START <= 1'b0;
      LINE_END   <= 1'b0;
      LINE_COLOR <= 2'd0;
      led_q      <= 3'b000;
      cidx       <= 2'd0;
      LINE_CNT   <= '0;
    end else begin
      LINE_START <= 1'b0;
      if (LINE_END) begin
        LINE_CNT <= LINE_CNT + 16'd1;
      end
      case (state)
        IDLE: begin
          if (start_now) begin
            state      <= SI_PH;
            cnt        <= '0;
            SI         <= 1'b1;
            LINE_START <= 1'b1;
            if (RGB_MODE) begin
              led_q      <= 3'b001 << cidx;
              LINE_COLOR <= cidx;
              cidx       <= (cidx == 2'd2) ? 2'd0 : (cidx + 2'd1);
            end else begin
              led_q      <= 3'b111;
              LINE_COLOR <= 2'd3;
            end
          end
        end
        SI_PH: begin
          if (cnt == CNT_W'(SI_WIDTH - 1)) begin
            state <= DUMMY;
            cnt   <= '0;
            SI    <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DUMMY: begin
          if (cnt == CNT_W'(DUMMY_PIX - 1)) begin
            state     <= ACTIVE;
            cnt       <= '0;
            PIX_VALID <= 1'b1;
            PIX_IDX   <= '0;
            LINE_END  <= (ACTIVE_PIX == 1);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ACTIVE: begin
          // PIX_IDX doubles as the active-phase counter.
          if (PIX_IDX == 12'(ACTIVE_PIX - 1)) begin
            state     <= IDLE;
            PIX_VALID <= 1'b0;
            PIX_IDX   <= '0;
            LINE_END  <= 1'b0;
          end else begin
            PIX_IDX  <= PIX_IDX + 12'd1;
            LINE_END <= (PIX_IDX == 12'(ACTIVE_PIX - 2));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign BUSY = (state != IDLE);

  // LEDs go dark as soon as the sequencer is disabled and idle; the latched
  // colour is kept so a re-enable without a new line shows the last colour.
  assign LED_RGB = ((state == IDLE) && !EN) ? 3'b000 : led_q;

endmodule

// File: tb/tb_cis_line_sequencer.sv
// tb_cis_line_sequencer
//   Drives cis_line_sequencer with directed and randomized line requests and
//   compares every output against a line-timing reference model that works on
//   absolute cycle numbers (line start time, pixel offsets, next timer fire).

module tb_cis_line_sequencer;

  localparam int SW = 1;
  localparam int D  = 89;
  localparam int A  = 2592;
  localparam int L  = SW + D + A;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        mode = 1'b0;
  logic [19:0] fp = '0;
  logic        trig = 1'b0;
  logic        rgb = 1'b0;

  logic        si;
  logic [2:0]  led_rgb;
  logic        pix_valid;
  logic [11:0] pix_idx;
  logic        line_start;
  logic        line_end;
  logic [1:0]  line_color;
  logic        busy;
  logic        overrun;
  logic [15:0] line_cnt;
  logic [15:0] ovr_cnt;

  int errors = 0;
  int checks = 0;

  cis_line_sequencer #(
    .DUMMY_PIX (D),
    .ACTIVE_PIX(A),
    .SI_WIDTH  (SW),
    .PERIOD_W  (20)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .EN         (en),
    .MODE       (mode),
    .FREE_PERIOD(fp),
    .LINE_TRIG  (trig),
    .RGB_MODE   (rgb),
    .SI         (si),
    .LED_RGB    (led_rgb),
    .PIX_VALID  (pix_valid),
    .PIX_IDX    (pix_idx),
    .LINE_START (line_start),
    .LINE_END   (line_end),
    .LINE_COLOR (line_color),
    .BUSY       (busy),
    .OVERRUN    (overrun),
    .LINE_CNT   (line_cnt),
    .OVR_CNT    (ovr_cnt)
  );

  always #5 clk = ~clk;

  logic [54:0] dut_vec;
  assign dut_vec = {si, led_rgb, pix_valid, pix_idx, line_start, line_end,
                    line_color, busy, overrun, line_cnt, ovr_cnt};

  // Reference model: a line is fully described by its start cycle m_t0.
  int       cyc = 0;
  bit       m_in_line = 0;
  int       m_t0 = 0;
  bit       m_pending = 0;
  int       m_cidx = 0;
  logic [2:0] m_led = 3'b000;
  logic [1:0] m_color = 2'd0;
  int       m_lcnt = 0;
  int       m_ocnt = 0;
  bit       m_ovr = 0;
  bit       m_trun = 0;
  int       m_next_fire = 0;

  always @(posedge clk) begin
    int  pos;
    bit  bsy, fire, rq, start;
    pos = cyc - m_t0;
    bsy = m_in_line && pos >= 0 && pos < L;
    if (rst) begin
      m_in_line = 0; m_pending = 0; m_cidx = 0; m_led = 3'b000; m_color = 2'd0;
      m_lcnt = 0; m_ocnt = 0; m_ovr = 0; m_trun = 0;
    end else begin
      fire = 0;
      if (en && !mode) begin
        if (!m_trun) begin
          m_trun = 1;
          m_next_fire = cyc + int'(fp) - 1;
        end
        if (cyc == m_next_fire) begin
          fire = (fp != 0);
          m_next_fire = cyc + int'(fp);
        end
      end else begin
        m_trun = 0;
      end
      rq = en && (mode ? trig : fire);
      if (bsy && pos == L - 1) m_lcnt = (m_lcnt + 1) % 65536;
      m_ovr = rq && m_pending;
      if (m_ovr && m_ocnt < 65535) m_ocnt++;
      start = 0;
      if (!en) m_pending = 0;
      else if (!bsy) begin
        start = m_pending || rq;
        m_pending = 0;
      end else if (rq) m_pending = 1;
      if (start) begin
        m_in_line = 1;
        m_t0 = cyc + 1;
        if (rgb) begin
          m_led = 3'(1 << m_cidx);
          m_color = 2'(m_cidx);
          m_cidx = (m_cidx + 1) % 3;
        end else begin
          m_led = 3'b111;
          m_color = 2'd3;
        end
      end
    end
    cyc = cyc + 1;
  end

  function automatic logic [54:0] exp_vec();
    int pos;
    bit bsy, si_e, ls_e, pv_e, le_e;
    logic [11:0] idx_e;
    logic [2:0] led_e;
    pos   = cyc - m_t0;
    bsy   = m_in_line && pos >= 0 && pos < L;
    si_e  = bsy && pos < SW;
    ls_e  = bsy && pos == 0;
    pv_e  = bsy && pos >= SW + D;
    idx_e = pv_e ? 12'(pos - SW - D) : 12'd0;
    le_e  = bsy && pos == L - 1;
    led_e = (!bsy && !en) ? 3'b000 : m_led;
    return {si_e, led_e, pv_e, idx_e, ls_e, le_e, m_color, bsy, m_ovr,
            16'(m_lcnt), 16'(m_ocnt)};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; mode = 1'b0; trig = 1'b0; rgb = 1'b0; fp = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b1; mode = 1'b1; trig = 1'b1; rgb = 1'b1; fp = 20'd7;
    repeat (2) @(negedge clk);
    checks++;
    if (dut_vec !== 55'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h want=0", dut_vec);
    end
    rst = 1'b0; en = 1'b0; trig = 1'b0;
    @(negedge clk);
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL reset_idle got=%h want=%h", dut_vec, exp_vec());
    end
    checks++;
    if (led_rgb !== 3'b000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_led_busy led=%b busy=%b want 000/0", led_rgb, busy);
    end
  endtask

  task automatic test_single_line();
    do_reset();
    for (int k = 0; k <= 2700; k++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL single_line k=%0d got=%h want=%h", k, dut_vec, exp_vec());
      end
      if (k == 11) begin
        checks++;
        if (si !== 1'b1 || line_start !== 1'b1 || led_rgb !== 3'b111 || line_color !== 2'd3) begin
          errors++;
          $display("FAIL single_si k=11 si=%b ls=%b led=%b col=%0d want 1/1/111/3", si, line_start, led_rgb, line_color);
        end
      end
      if (k == 100 || k == 101) begin
        checks++;
        if (pix_valid !== (k == 101) || pix_idx !== 12'd0) begin
          errors++;
          $display("FAIL single_first_pix k=%0d valid=%b idx=%0d", k, pix_valid, pix_idx);
        end
      end
      if (k == 2692) begin
        checks++;
        if (line_end !== 1'b1 || pix_idx !== 12'd2591 || line_cnt !== 16'd0) begin
          errors++;
          $display("FAIL single_end end=%b idx=%0d cnt=%0d want 1/2591/0", line_end, pix_idx, line_cnt);
        end
      end
      if (k == 2693) begin
        checks++;
        if (line_cnt !== 16'd1 || pix_valid !== 1'b0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL single_count cnt=%0d valid=%b busy=%b want 1/0/0", line_cnt, pix_valid, busy);
        end
      end
      mode = 1'b1; en = 1'b1;
      trig = (k == 10);
    end
    trig = 1'b0;
  endtask

  task automatic test_rgb_rotation();
    logic [2:0] want_led [4];
    want_led[0] = 3'b001; want_led[1] = 3'b010; want_led[2] = 3'b100; want_led[3] = 3'b001;
    do_reset();
    for (int k = 0; k <= 15012; k++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL rgb k=%0d got=%h want=%h", k, dut_vec, exp_vec());
      end
      if (k >= 11 && (k - 11) % 5000 == 0) begin
        checks++;
        if (led_rgb !== want_led[(k - 11) / 5000] || line_color !== 2'((k - 11) / 5000 % 3)) begin
          errors++;
          $display("FAIL rgb_color k=%0d led=%b col=%0d want %b/%0d", k, led_rgb, line_color,
                   want_led[(k - 11) / 5000], (k - 11) / 5000 % 3);
        end
      end
      mode = 1'b1; en = 1'b1; rgb = 1'b1;
      trig = (k >= 10 && (k - 10) % 5000 == 0);
    end
    trig = 1'b0;
  endtask

  task automatic test_pending_overrun();
    do_reset();
    for (int k = 0; k <= 5380; k++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL pend k=%0d got=%h want=%h", k, dut_vec, exp_vec());
      end
      if (k == 211) begin
        checks++;
        if (overrun !== 1'b1 || ovr_cnt !== 16'd1) begin
          errors++;
          $display("FAIL pend_overrun ovr=%b cnt=%0d want 1/1", overrun, ovr_cnt);
        end
      end
      if (k == 2693 || k == 2694) begin
        checks++;
        if (si !== (k == 2694) || busy !== (k == 2694)) begin
          errors++;
          $display("FAIL pend_gap k=%0d si=%b busy=%b", k, si, busy);
        end
      end
      if (k == 5376) begin
        checks++;
        if (line_cnt !== 16'd2 || ovr_cnt !== 16'd1) begin
          errors++;
          $display("FAIL pend_counts lines=%0d ovr=%0d want 2/1", line_cnt, ovr_cnt);
        end
      end
      mode = 1'b1; en = 1'b1;
      trig = (k == 10 || k == 110 || k == 210);
    end
    trig = 1'b0;
  endtask

  task automatic test_free_run();
    int starts = 0;
    int ovrs = 0;
    do_reset();
    fp = 20'd4000;
    for (int k = 0; k <= 42700; k++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL free k=%0d got=%h want=%h", k, dut_vec, exp_vec());
      end
      if (line_start === 1'b1) starts++;
      if (overrun === 1'b1) ovrs++;
      if (k == 4000) begin
        checks++;
        if (si !== 1'b1) begin
          errors++;
          $display("FAIL free_first_start si=%b want 1", si);
        end
      end
      mode = 1'b0;
      en = (k < 40000);
    end
    checks++;
    if (starts != 10 || ovrs != 0 || line_cnt !== 16'd10 || ovr_cnt !== 16'd0) begin
      errors++;
      $display("FAIL free_count starts=%0d ovr_pulses=%0d lines=%0d ovr=%0d want 10/0/10/0", starts, ovrs, line_cnt, ovr_cnt);
    end
    fp = 20'd1000;
    for (int k = 0; k <= 6000; k++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL fast k=%0d got=%h want=%h", k, dut_vec, exp_vec());
      end
      if (k == 3682) begin
        checks++;
        if (busy !== 1'b0 || line_cnt !== 16'd11) begin
          errors++;
          $display("FAIL fast_gap busy=%b lines=%0d want 0/11", busy, line_cnt);
        end
      end
      if (k == 3683) begin
        checks++;
        if (si !== 1'b1 || line_start !== 1'b1) begin
          errors++;
          $display("FAIL fast_b2b si=%b ls=%b want 1/1", si, line_start);
        end
      end
      en = 1'b1;
    end
    checks++;
    if (ovr_cnt !== 16'd3) begin
      errors++;
      $display("FAIL fast_ovr_cnt got=%0d want 3", ovr_cnt);
    end
  endtask

  task automatic test_reset_midline();
    do_reset();
    for (int k = 0; k <= 1120; k++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL abort k=%0d got=%h want=%h", k, dut_vec, exp_vec());
      end
      if (k == 1101) begin
        checks++;
        if (pix_idx !== 12'd1000) begin
          errors++;
          $display("FAIL abort_idx got=%0d want 1000", pix_idx);
        end
      end
      if (k == 1102) begin
        checks++;
        if (dut_vec !== 55'd0) begin
          errors++;
          $display("FAIL abort_zero got=%h want=0", dut_vec);
        end
      end
      if (k == 1111) begin
        checks++;
        if (led_rgb !== 3'b001 || line_color !== 2'd0) begin
          errors++;
          $display("FAIL abort_color led=%b col=%0d want 001/0", led_rgb, line_color);
        end
      end
      mode = 1'b1; en = 1'b1; rgb = 1'b1;
      rst  = (k == 1101);
      trig = (k == 10 || k == 1110);
    end
    trig = 1'b0; rst = 1'b0;
  endtask

  task automatic test_en_drop();
    int late_si = 0;
    do_reset();
    for (int k = 0; k <= 3000; k++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL endrop k=%0d got=%h want=%h", k, dut_vec, exp_vec());
      end
      if (k > 2692 && si === 1'b1) late_si++;
      if (k == 601) begin
        checks++;
        if (pix_idx !== 12'd500) begin
          errors++;
          $display("FAIL endrop_idx got=%0d want 500", pix_idx);
        end
      end
      if (k == 2692) begin
        checks++;
        if (line_end !== 1'b1) begin
          errors++;
          $display("FAIL endrop_end got=%b want 1", line_end);
        end
      end
      if (k == 2693) begin
        checks++;
        if (line_cnt !== 16'd1 || led_rgb !== 3'b000 || busy !== 1'b0) begin
          errors++;
          $display("FAIL endrop_idle lines=%0d led=%b busy=%b want 1/000/0", line_cnt, led_rgb, busy);
        end
      end
      mode = 1'b1;
      en   = (k < 601);
      trig = (k == 10 || k == 200);
    end
    checks++;
    if (late_si != 0) begin
      errors++;
      $display("FAIL endrop_no_si late_si=%0d want 0", late_si);
    end
    trig = 1'b0;
  endtask

  task automatic test_random();
    int en_hold = 0;
    do_reset();
    mode = 1'b1; rgb = 1'b1;
    fp = 20'(1500 + $urandom_range(0, 2500));
    for (int k = 0; k < 6000; k++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL random k=%0d got=%h want=%h", k, dut_vec, exp_vec());
      end
      rst = ($urandom_range(0, 2999) == 0);
      if ($urandom_range(0, 799) == 0) mode = ~mode;
      if ($urandom_range(0, 999) == 0) rgb = ~rgb;
      if ($urandom_range(0, 1999) == 0) fp = 20'(1500 + $urandom_range(0, 2500));
      if (en_hold > 0) en_hold--;
      else if ($urandom_range(0, 1499) == 0) en_hold = $urandom_range(1, 60);
      en   = (en_hold == 0);
      trig = mode && ($urandom_range(0, 699) == 0);
    end
    rst = 1'b0; trig = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_line();
    test_rgb_rotation();
    test_pending_overrun();
    test_free_run();
    test_reset_midline();
    test_en_drop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
